lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit sitting between the RV32I execute stage and the data memory port. It accepts one load or store per transaction from the core over a valid/ready handshake. It converts the transaction into a word-aligned memory request with byte enables and replicated store data, then waits for grant and read data. It returns a sign- or zero-extended load result, or a misalignment/illegal error, as a one-cycle response pulse.

## Interface
- Parameters:
  - `MEM_ADDR_W`, default 32: width of the byte address on both sides.
- Ports:
  - `clk` in 1: clock.
  - `rst` in 1: reset, synchronous, active-high.
  - `req_valid` in 1: core presents an operation.
  - `req_ready` out 1: unit is idle and can accept an operation.
  - `req_we` in 1: 1 = store, 0 = load.
  - `req_funct3` in 3: RV32I LOAD/STORE funct3.
  - `req_addr` in MEM_ADDR_W: byte address.
  - `req_wdata` in 32: store data from rs2.
  - `resp_valid` out 1: one-cycle completion pulse.
  - `resp_rdata` out 32: extended load data; 0 for stores and errors.
  - `resp_err` out 1: misaligned or illegal funct3; qualified by `resp_valid`.
  - `mem_req` out 1: memory request, held until granted.
  - `mem_we` out 1: write request.
  - `mem_addr` out MEM_ADDR_W: word address, bits [1:0] forced to 0.
  - `mem_be` out 4: byte enables.
  - `mem_wdata` out 32: lane-replicated store data.
  - `mem_gnt` in 1: memory accepts the request in this cycle.
  - `mem_rvalid` in 1: load data valid; earliest the cycle after `mem_gnt`.
  - `mem_rdata` in 32: raw word from memory.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, latch we/funct3/addr/wdata.
  - Go to RESP if the operation is erroneous; otherwise go to REQ.
- Error conditions:
  - Load funct3 outside {000,001,010,100,101}.
  - Store funct3 outside {000,001,010}.
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - An erroneous operation never asserts `mem_req`.
- REQ:
  - `mem_req=1` with all `mem_*` outputs stable until `mem_gnt`.
  - On grant: store → RESP; load → WAIT.
- WAIT: hold until `mem_rvalid`, register the extended data, then go to RESP.
- RESP: `resp_valid=1` for exactly one cycle, then IDLE.
- Only one transaction is outstanding. `req_ready=0` in every state except IDLE.
- Byte enables, where off = addr[1:0]:
  - SB: 4'b0001<<off.
  - SH: 4'b0011<<off.
  - SW: 4'b1111.
  - Loads drive the same pattern for their size.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load extraction from `mem_rdata`:
  - LB/LBU: byte at off, sign-/zero-extended.
  - LH/LHU: halfword at off (0 or 2), sign-/zero-extended.
  - LW: the full word.
- `mem_rvalid` outside WAIT is ignored.

## Timing
- Reset values: state IDLE; `req_ready=1`; `resp_valid=0`, `resp_rdata=0`, `resp_err=0`; `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_be=0`, `mem_wdata=0`.
- Minimum latency, accept at cycle 0:
  - Store: REQ at cycle 1 with gnt, `resp_valid` at cycle 2.
  - Load: REQ at cycle 1 with gnt, rvalid at cycle 2, `resp_valid` at cycle 3.
  - Error: `resp_valid` at cycle 1.
- Each gnt stall cycle and each rvalid stall cycle adds one cycle.
- `resp_rdata` and `resp_err` are registered and valid only while `resp_valid=1`. They hold their value until the next response.
- Back-to-back: a new request is accepted in the cycle after RESP, since IDLE is re-entered then.
- Reset mid-operation:
  - Return to IDLE next cycle and deassert `mem_req`.
  - No `resp_valid` is produced for the aborted operation.
  - A late `mem_rvalid` is ignored.

## Structure
- Package `lsu_pkg`:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - The state enum.
  - Function `be_for(funct3, off)`.
- Sub-module `load_align`: combinational; inputs funct3, offset, raw word; output the extended 32-bit result. It is reusable by the fetch/debug path.
- The top holds the FSM, latches, error check, byte-enable and store-data generation.

## Test plan
- SB addr 0x0000_0013, wdata 0x1234_56AB, gnt immediate → `mem_addr=0x10`, `mem_be=4'b1000`, `mem_wdata=0xABABABAB`, `resp_valid` at cycle 2, `resp_err=0`.
- LH addr 0x22, gnt immediate, rdata 0x8001_7F00 returned after 3 rvalid stall cycles → `resp_rdata=0xFFFF_8001` at cycle 6. LHU with the same data → 0x0000_8001.
- LW addr 0x41 → `resp_valid` and `resp_err=1` at cycle 1, `mem_req` never asserted. Load funct3=3'b011 also → err.
- SW addr 0x80, `mem_gnt` low for 4 cycles → `mem_req`/`mem_addr`/`mem_wdata` stable throughout, response 1 cycle after gnt.
- Two back-to-back loads, LB 0x3 on rdata 0x80_00_00_00 → 0xFFFF_FF80, then LBU 0x3 → 0x0000_0080. `req_ready` low between acceptances.
- Assert `rst` while in WAIT, then pulse `mem_rvalid` → no `resp_valid`, `mem_req=0`, `req_ready=1` the cycle after reset releases.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// lane helpers used by the controller and the load aligner.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_e;

    // Size is carried in funct3[1:0], so LBU/LHU share the LB/LH pattern.
    function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic op_err(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] off);
        logic legal;
        logic misaligned;
        if (we) begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        case (funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and sign/zero-extends a byte, halfword or word from a raw memory word.
module load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data_o = {24'h0, byte_v};
            F3_H:    data_o = {{16{half_v[15]}}, half_v};
            F3_HU:   data_o = {16'h0, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store unit: one outstanding transaction, word-aligned memory
// requests with byte enables, registered one-cycle response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [MEM_ADDR_W-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    lsu_state_e            state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [31:0]           load_data;
    logic [31:0]           store_data;

    load_align u_load_align (
        .funct3_i (f3_q),
        .off_i    (addr_q[1:0]),
        .rdata_i  (mem_rdata),
        .data_o   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Response registers only change on entry to StResp so they hold between responses.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (op_err(req_we, req_funct3, req_addr[1:0])) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    if (we_q) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b0;
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    rdata_d = load_data;
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00:   store_data = {4{wdata_q[7:0]}};
            2'b01:   store_data = {2{wdata_q[15:0]}};
            default: store_data = wdata_q;
        endcase
    end

    // Memory outputs are gated by mem_req so they read zero outside a request.
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? {addr_q[MEM_ADDR_W-1:2], 2'b00} : '0;
    assign mem_be     = mem_req ? be_for(f3_q, addr_q[1:0]) : 4'b0000;
    assign mem_wdata  = (mem_req && we_q) ? store_data : 32'h0;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, random transactions
// against an arithmetic reference model, and a reset-during-wait sequence.
module tb_lsu_ctrl;

    localparam int AW = 32;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    lsu_ctrl #(.MEM_ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gst;
        int          rvs;
        logic        err;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ma;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: sizes, masks and lane replication from plain arithmetic.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int gst, input int rvs,
                         output logic err, output logic [31:0] rd, output logic [3:0] be,
                         output logic [31:0] wd, output logic [31:0] ma, output int lat);
        int sz;
        int off;
        logic legal;
        logic [31:0] mask;
        logic [31:0] v;
        off = int'(addr % 4);
        case (f3[1:0])
            2'b00:   sz = 1;
            2'b01:   sz = 2;
            2'b10:   sz = 4;
            default: sz = 0;
        endcase
        legal = (sz != 0) && (f3[2] == 1'b0 || (!we && sz < 4));
        err   = !legal || ((off % sz) != 0);
        be    = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % (sz == 0 ? 1 : sz)) +: 8];
        ma    = addr - 32'(off);
        mask  = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
        v     = (rdata >> (8 * off)) & mask;
        if (!f3[2] && sz < 4 && sz > 0 && v[8*sz-1]) v = v | ~mask;
        rd    = (err || we) ? 32'h0 : v;
        lat   = err ? 1 : (we ? 2 + gst : 3 + gst + rvs);
    endtask

    // Drives one transaction and acts as the memory; returns what was observed.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gst, input int rvs,
                          output logic [31:0] o_rd, output logic o_err, output int o_lat,
                          output logic [3:0] o_be, output logic [31:0] o_wd,
                          output logic [31:0] o_ma, output logic o_mwe, output logic o_saw,
                          output logic o_stable, output logic o_ready_ok);
        int cyc;
        int reqc;
        int gcyc;
        logic granted;
        o_rd = 32'hX; o_err = 1'bX; o_lat = -1; o_be = 4'h0; o_wd = 32'h0; o_ma = 32'h0;
        o_mwe = 1'b0; o_saw = 1'b0; o_stable = 1'b1;
        reqc = 0; gcyc = 0; granted = 1'b0;
        o_ready_ok = req_ready && !resp_valid;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        cyc = 1;
        while (cyc < 60) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (resp_valid) begin
                o_rd = resp_rdata; o_err = resp_err; o_lat = cyc;
                break;
            end
            if (req_ready) o_ready_ok = 1'b0;
            if (mem_req) begin
                if (!o_saw) begin
                    o_be = mem_be; o_wd = mem_wdata; o_ma = mem_addr; o_mwe = mem_we;
                end else if (mem_be !== o_be || mem_wdata !== o_wd || mem_addr !== o_ma ||
                             mem_we !== o_mwe) begin
                    o_stable = 1'b0;
                end
                o_saw = 1'b1;
                reqc++;
                if (reqc > gst) begin
                    mem_gnt = 1'b1;
                    if (!granted) gcyc = cyc;
                    granted = 1'b1;
                end else begin
                    mem_rvalid = 1'($urandom);
                end
            end
            if (granted && !we && cyc == gcyc + 1 + rvs) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
            end
            tick();
            cyc++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();
    endtask

    task automatic run_case(input string nm, input vec_t v);
        logic [31:0] rd, wd, ma;
        logic [3:0] be;
        logic err, mwe, saw, stable, rdy;
        int lat;
        do_txn(v.we, v.f3, v.addr, v.wdata, v.rdata, v.gst, v.rvs,
               rd, err, lat, be, wd, ma, mwe, saw, stable, rdy);
        chk({nm, ".ready"}, 32'(rdy), 32'd1);
        chk({nm, ".latency"}, 32'(lat), 32'(v.lat));
        chk({nm, ".err"}, 32'(err), 32'(v.err));
        chk({nm, ".rdata"}, rd, v.rd);
        if (v.err) begin
            chk({nm, ".no_mem_req"}, 32'(saw), 32'd0);
        end else begin
            chk({nm, ".mem_req"}, 32'(saw), 32'd1);
            chk({nm, ".be"}, 32'(be), 32'(v.be));
            chk({nm, ".addr"}, ma, v.ma);
            chk({nm, ".we"}, 32'(mwe), 32'(v.we));
            chk({nm, ".stable"}, 32'(stable), 32'd1);
            if (v.we) chk({nm, ".wdata"}, wd, v.wd);
        end
    endtask

    vec_t vt[13];

    initial begin
        vec_t r;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0;
        req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        //        we    f3      addr       wdata          rdata         gst rvs err rd            be       wd             ma        lat
        vt[0]  = '{1'b1, 3'b000, 32'h13,  32'h1234_56AB, 32'h0,        0, 0, 1'b0, 32'h0,        4'b1000, 32'hABAB_ABAB, 32'h10,  2};
        vt[1]  = '{1'b0, 3'b001, 32'h22,  32'h0,         32'h8001_7F00, 0, 3, 1'b0, 32'hFFFF_8001, 4'b1100, 32'h0,        32'h20,  6};
        vt[2]  = '{1'b0, 3'b101, 32'h22,  32'h0,         32'h8001_7F00, 0, 3, 1'b0, 32'h0000_8001, 4'b1100, 32'h0,        32'h20,  6};
        vt[3]  = '{1'b0, 3'b010, 32'h41,  32'h0,         32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,   1};
        vt[4]  = '{1'b0, 3'b011, 32'h40,  32'h0,         32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,   1};
        vt[5]  = '{1'b1, 3'b010, 32'h80,  32'hDEAD_BEEF, 32'h0,        4, 0, 1'b0, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h80,  6};
        vt[6]  = '{1'b0, 3'b000, 32'h3,   32'h0,         32'h8000_0000, 0, 0, 1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0,        32'h0,   3};
        vt[7]  = '{1'b0, 3'b100, 32'h3,   32'h0,         32'h8000_0000, 0, 0, 1'b0, 32'h0000_0080, 4'b1000, 32'h0,        32'h0,   3};
        vt[8]  = '{1'b1, 3'b001, 32'h6,   32'h1111_BEEF, 32'h0,        0, 0, 1'b0, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h4,   2};
        vt[9]  = '{1'b1, 3'b001, 32'h5,   32'h0,         32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,   1};
        vt[10] = '{1'b1, 3'b100, 32'h0,   32'h0,         32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,   1};
        vt[11] = '{1'b0, 3'b010, 32'h100, 32'h0,         32'hCAFE_F00D, 1, 1, 1'b0, 32'hCAFE_F00D, 4'b1111, 32'h0,        32'h100, 5};
        vt[12] = '{1'b0, 3'b001, 32'h20,  32'h0,         32'h8001_7F00, 0, 0, 1'b0, 32'h0000_7F00, 4'b0011, 32'h0,        32'h20,  3};

        tick();
        tick();
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        chk("reset.resp_valid", 32'(resp_valid), 32'd0);
        chk("reset.resp_rdata", resp_rdata, 32'h0);
        chk("reset.resp_err", 32'(resp_err), 32'd0);
        chk("reset.mem_req", 32'(mem_req), 32'd0);
        chk("reset.mem_we", 32'(mem_we), 32'd0);
        chk("reset.mem_addr", mem_addr, 32'h0);
        chk("reset.mem_be", 32'(mem_be), 32'd0);
        chk("reset.mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) run_case($sformatf("vec%0d", i), vt[i]);

        // Reset while waiting for load data; the late rvalid must be ignored.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        tick();
        req_valid = 1'b0;
        chk("rstwait.mem_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("rstwait.in_wait", 32'(mem_req | req_ready), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        chk("rstwait.req_ready", 32'(req_ready), 32'd1);
        chk("rstwait.mem_req", 32'(mem_req), 32'd0);
        chk("rstwait.resp_valid0", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_rvalid = 1'b0;
            chk($sformatf("rstwait.resp_valid%0d", i + 1), 32'(resp_valid), 32'd0);
            chk($sformatf("rstwait.idle%0d", i + 1), 32'(req_ready), 32'd1);
        end
        run_case("postrst", vt[11]);

        for (int n = 0; n < 150; n++) begin
            r.we    = 1'($urandom);
            r.f3    = 3'($urandom);
            r.addr  = $urandom;
            r.wdata = $urandom;
            r.rdata = $urandom;
            r.gst   = int'($urandom_range(0, 3));
            r.rvs   = int'($urandom_range(0, 3));
            model(r.we, r.f3, r.addr, r.wdata, r.rdata, r.gst, r.rvs,
                  r.err, r.rd, r.be, r.wd, r.ma, r.lat);
            run_case($sformatf("rnd%0d", n), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
